router_out_alloc: RTL and testbench
===================================

// Module: router_out_alloc
// PURPOSE
//  Per-output-port switch/VC allocator for the 5-port, 2-VC mesh router. One instance per output port.
//  Grants one input port ownership of the output for one whole packet (head..tail), selected by round-robin.
//  Tracks downstream buffer credits per VC. Drives the crossbar select and the input-buffer pop strobes.
// PARAMETERS
//  NPORT   5   number of input requesters (ports 0..4)
//  NVC     2   virtual channels per link
//  DEPTH   4   downstream input-buffer depth per VC = initial credit count
//  SELW    3   width of SEL, $clog2(NPORT)
//  CW      3   credit counter width, $clog2(DEPTH+1)
// PORTS
//  clk        in   1      clock
//  RST_       in   1      reset, asynchronous, active-low
//  REQ        in   NPORT  input i has a routed head flit at its buffer head, targeting this output
//  REQ_VCH    in   NPORT  VC of input i's packet; the output VC equals the input VC
//  FLIT_VALID in   NPORT  input i presents a flit this cycle
//  FLIT_TAIL  in   NPORT  flit presented by input i is a tail (a single-flit packet has head and tail both set)
//  IACK       in   NVC    downstream credit return, one pulse = one slot freed on that VC
//  ILCK       in   NVC    downstream VC locked by another packet; blocks new grants on that VC
//  GRANT      out  NPORT  one-hot owner of this output (all zero when idle)
//  SEL        out  SELW   binary index of owner, for the crossbar mux
//  OVCH       out  1      VC of the current packet
//  FWD        out  NPORT  one-hot pop strobe to the owner's input buffer, same cycle as OVALID
//  OVALID     out  1      flit forwarded on the output link this cycle
//  CREDIT     out  NVC*CW credit counters, VC0 in the LSBs
//  ERR        out  1      sticky credit-overflow flag
// BEHAVIOUR
//  Reset (RST_=0, async): state=IDLE, GRANT=0, SEL=0, OVCH=0, FWD=0, OVALID=0, CREDIT[v]=DEPTH, ERR=0, RR pointer=0.
//  States: IDLE, BUSY.
//  IDLE:
//   eligible[i] = REQ[i] & ~ILCK[REQ_VCH[i]] & (CREDIT[REQ_VCH[i]] != 0).
//   Round-robin search starts at the pointer. The winner w is registered: GRANT=1<<w, SEL=w, OVCH=REQ_VCH[w], state goes to BUSY.
//   On the grant edge the pointer becomes (w+1) mod NPORT. With no eligible input, nothing changes.
//  BUSY (combinational forward):
//   fwd = FLIT_VALID[SEL] & (CREDIT[OVCH] != 0).
//   FWD = GRANT & {NPORT{fwd}}; OVALID = fwd. Inputs other than SEL are ignored.
//   If fwd & FLIT_TAIL[SEL]: the next state is IDLE and GRANT/SEL clear. Re-arbitration happens in the following IDLE cycle.
//   ILCK is not re-checked while BUSY.
//  Latency: REQ seen in cycle N -> GRANT in cycle N+1. The head flit is forwarded in cycle N+1 if valid.
//   The earliest re-grant after a tail in cycle M is cycle M+2.
//  Credits (per VC v, every cycle, in both states):
//   dec = OVALID & (OVCH==v); inc = IACK[v].
//   inc & dec: counter unchanged. dec only: -1; a dec at 0 cannot occur because fwd is gated.
//   inc only: +1, saturating at DEPTH; an IACK while at DEPTH leaves the count at DEPTH and sets ERR.
//  CREDIT=0 in BUSY stalls the packet with FWD=0 and ownership held. Forwarding resumes in the cycle the credit becomes nonzero.
//  ERR clears only on reset. Reset mid-packet drops ownership immediately; the upstream resends the packet.
// STRUCTURE
//  router_pkg:
//   FLIT_W=35, NPORT=5, NVC=2, flit-type field FLIT[34:33] (HEAD=2'b01, BODY=2'b10, TAIL=2'b11, SINGLE=2'b00),
//   port indices P_LOCAL..P_WEST, state enum {IDLE, BUSY}.
//  Sub-module rr_arbiter #(N):
//   inputs req[N], en; outputs gnt one-hot and gnt_idx.
//   Internal pointer advances to winner+1 when en & |req.
//  Top-level holds the FSM, owner registers and the credit counters.
// TESTING
//  Reset release, no REQ -> GRANT=0, OVALID=0, CREDIT={3'd4,3'd4}, ERR=0.
//  REQ=5'b00100, VC0, then 3 flits (tail on 3rd) valid back-to-back -> GRANT=5'b00100 and SEL=2 next cycle;
//   FWD on 3 consecutive cycles; CREDIT[0]=1; IDLE after the tail.
//  REQ=5'b11111 held, every packet a single flit, IACK returned each cycle -> grants in order 0,1,2,3,4,0; no input starved.
//  VC1 packet of 6 flits, DEPTH=4, no IACK -> 4 flits forwarded, then a stall with GRANT held.
//   An IACK[1] pulse -> exactly one more flit; IACK coincident with a forward -> CREDIT unchanged.
//  ILCK=2'b01, REQ=5'b00011 (port0 VC0, port1 VC1) -> port1 granted; port0 granted only after ILCK drops and port1's tail.
//  RST_ low mid-packet, asynchronously -> GRANT=0, CREDIT=DEPTH at once. An IACK at full -> ERR=1 sticky.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: flit layout, port numbering, allocator state encoding.
package router_pkg;

  localparam int FLIT_W = 35;
  localparam int NPORT  = 5;
  localparam int NVC    = 2;
  localparam int DEPTH  = 4;
  localparam int SELW   = $clog2(NPORT);
  localparam int CW     = $clog2(DEPTH + 1);

  // Flit-type field position inside a flit
  localparam int FTYPE_HI = 34;
  localparam int FTYPE_LO = 33;

  typedef enum logic [1:0] {
    FT_SINGLE = 2'b00,
    FT_HEAD   = 2'b01,
    FT_BODY   = 2'b10,
    FT_TAIL   = 2'b11
  } flit_type_t;

  typedef enum logic [2:0] {
    P_LOCAL = 3'd0,
    P_NORTH = 3'd1,
    P_EAST  = 3'd2,
    P_SOUTH = 3'd3,
    P_WEST  = 3'd4
  } port_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic flit_type_t flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_t'(flit[FTYPE_HI:FTYPE_LO]);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first requester at or after the pointer wins; the
// pointer moves just past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;

  // Scan from the highest offset down so the lowest offset from the pointer wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt                          = '0;
        gnt[(int'(ptr) + k) % N]     = 1'b1;
        gnt_idx                      = IW'((int'(ptr) + k) % N);
      end
    end
  end

  // Advance the pointer past the winner on every taken grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en && (|req)) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/router_out_alloc.sv
// Per-output-port packet allocator: owns the output for a whole packet,
// tracks downstream credits per VC and drives crossbar select / pop strobes.
module router_out_alloc #(
  parameter int NPORT = router_pkg::NPORT,
  parameter int NVC   = router_pkg::NVC,
  parameter int DEPTH = router_pkg::DEPTH,
  parameter int SELW  = router_pkg::SELW,
  parameter int CW    = router_pkg::CW
) (
  input  logic              clk,
  input  logic              RST_,
  input  logic [NPORT-1:0]  REQ,
  input  logic [NPORT-1:0]  REQ_VCH,
  input  logic [NPORT-1:0]  FLIT_VALID,
  input  logic [NPORT-1:0]  FLIT_TAIL,
  input  logic [NVC-1:0]    IACK,
  input  logic [NVC-1:0]    ILCK,
  output logic [NPORT-1:0]  GRANT,
  output logic [SELW-1:0]   SEL,
  output logic              OVCH,
  output logic [NPORT-1:0]  FWD,
  output logic              OVALID,
  output logic [NVC*CW-1:0] CREDIT,
  output logic              ERR
);

  import router_pkg::*;

  state_t           state;
  logic [CW-1:0]    credit [NVC];
  logic [NPORT-1:0] eligible;
  logic [NPORT-1:0] arb_gnt;
  logic [SELW-1:0]  arb_idx;
  logic             arb_en;
  logic             fwd;
  logic [NVC-1:0]   dec;

  // A requester may win only if its VC is unlocked and has a free downstream slot
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      eligible[i] = REQ[i] & ~ILCK[REQ_VCH[i]] & (credit[REQ_VCH[i]] != '0);
    end
  end

  assign arb_en = (state == IDLE);

  rr_arbiter #(
    .N  (NPORT),
    .IW (SELW)
  ) u_arb (
    .clk     (clk),
    .rst_n   (RST_),
    .req     (eligible),
    .en      (arb_en),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Owner forwards whenever it presents a flit and its VC has credit
  always_comb begin
    fwd    = (state == BUSY) & FLIT_VALID[SEL] & (credit[OVCH] != '0);
    FWD    = GRANT & {NPORT{fwd}};
    OVALID = fwd;
    for (int v = 0; v < NVC; v++) begin
      dec[v] = fwd & (OVCH == 1'(v));
    end
  end

  // Ownership FSM: grant a whole packet, release after the tail is forwarded
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      state <= IDLE;
      GRANT <= '0;
      SEL   <= '0;
      OVCH  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            state <= BUSY;
            GRANT <= arb_gnt;
            SEL   <= arb_idx;
            OVCH  <= REQ_VCH[arb_idx];
          end
        end
        BUSY: begin
          if (fwd & FLIT_TAIL[SEL]) begin
            state <= IDLE;
            GRANT <= '0;
            SEL   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Credit counters: forward consumes, IACK returns; a return while full flags ERR
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      for (int v = 0; v < NVC; v++) begin
        credit[v] <= CW'(DEPTH);
      end
      ERR <= 1'b0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        if (IACK[v] & ~dec[v]) begin
          if (credit[v] == CW'(DEPTH)) begin
            ERR <= 1'b1;
          end else begin
            credit[v] <= credit[v] + CW'(1);
          end
        end else if (dec[v] & ~IACK[v]) begin
          credit[v] <= credit[v] - CW'(1);
        end
      end
    end
  end

  // Flatten the counters, VC0 in the low bits
  always_comb begin
    for (int v = 0; v < NVC; v++) begin
      CREDIT[v*CW +: CW] = credit[v];
    end
  end

endmodule

// File: tb/tb_router_out_alloc.sv
// Bench for router_out_alloc: upstream packet sources and a downstream credit
// returner drive the DUT; an abstract allocator model predicts each cycle.
module tb_router_out_alloc;

  localparam int NPORT = 5;
  localparam int NVC   = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] REQ, REQ_VCH, FLIT_VALID, FLIT_TAIL;
  logic [1:0] IACK, ILCK;
  logic [4:0] GRANT, FWD;
  logic [2:0] SEL;
  logic       OVCH, OVALID, ERR;
  logic [5:0] CREDIT;

  router_out_alloc dut (
    .clk(clk), .RST_(rst_n), .REQ(REQ), .REQ_VCH(REQ_VCH), .FLIT_VALID(FLIT_VALID),
    .FLIT_TAIL(FLIT_TAIL), .IACK(IACK), .ILCK(ILCK), .GRANT(GRANT), .SEL(SEL),
    .OVCH(OVCH), .FWD(FWD), .OVALID(OVALID), .CREDIT(CREDIT), .ERR(ERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       ovch;
    logic [4:0] fwd;
    logic       ovalid;
    logic [5:0] credit;
    logic       err;
  } stat_t;

  typedef struct {
    int cyc;
    int port;
    int vc;
  } fwd_t;

  stat_t stat_q[$];
  fwd_t  fwd_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  int m_owner, m_ovc, m_ptr;
  int m_cred[2];
  bit m_err;

  // Upstream sources and downstream returner
  int plen[5], psent[5], pvc[5];
  int pend[2];
  bit [4:0] ld_mask = '0;
  int ld_prob = 0, ld_maxlen = 1, ld_vcmode = 0;
  int vprob = 100, ds_prob = 100;
  bit ds_en = 1'b1, lck_rand = 1'b0;
  logic [1:0] lck = '0, force_iack = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ovc = 0; m_ptr = 0; m_err = 1'b0;
    m_cred[0] = DEPTH; m_cred[1] = DEPTH;
  endtask

  task automatic zero_inputs();
    REQ = '0; REQ_VCH = '0; FLIT_VALID = '0; FLIT_TAIL = '0; IACK = '0; ILCK = '0;
  endtask

  task automatic clear_sources();
    for (int p = 0; p < NPORT; p++) begin plen[p] = 0; psent[p] = 0; pvc[p] = 0; end
    pend[0] = 0; pend[1] = 0;
  endtask

  // One clock cycle: build inputs, predict outputs, advance model and sources
  task automatic step();
    logic [4:0] req, vch, fv, tl;
    logic [1:0] ik;
    stat_t e;
    fwd_t  f;
    bit    fw;
    int    own, oc[2];
    @(posedge clk);
    #1;
    cyc++;
    if (lck_rand) lck = {($urandom_range(9) == 0), ($urandom_range(9) == 0)};
    for (int p = 0; p < NPORT; p++) begin
      req[p] = (plen[p] > 0) && (psent[p] == 0);
      vch[p] = pvc[p][0];
      fv[p]  = (plen[p] > 0) && ($urandom_range(99) < vprob);
      tl[p]  = (plen[p] > 0) && (psent[p] == plen[p] - 1);
    end
    for (int v = 0; v < NVC; v++) begin
      ik[v] = force_iack[v] || (ds_en && pend[v] > 0 && $urandom_range(99) < ds_prob);
      if (ik[v] && pend[v] > 0) pend[v]--;
    end
    REQ = req; REQ_VCH = vch; FLIT_VALID = fv; FLIT_TAIL = tl; IACK = ik; ILCK = lck;

    own = m_owner;
    fw  = (own >= 0) && fv[own] && (m_cred[m_ovc] > 0);
    e.cyc    = cyc;
    e.grant  = (own >= 0) ? 5'(1 << own) : 5'd0;
    e.sel    = (own >= 0) ? 3'(own) : 3'd0;
    e.ovch   = 1'(m_ovc);
    e.fwd    = fw ? 5'(1 << own) : 5'd0;
    e.ovalid = fw;
    e.credit = {3'(m_cred[1]), 3'(m_cred[0])};
    e.err    = m_err;
    stat_q.push_back(e);
    if (fw) begin
      f.cyc = cyc; f.port = own; f.vc = m_ovc;
      fwd_q.push_back(f);
    end

    oc[0] = m_cred[0]; oc[1] = m_cred[1];
    for (int v = 0; v < NVC; v++) begin
      if (ik[v] && !(fw && m_ovc == v)) begin
        if (m_cred[v] == DEPTH) m_err = 1'b1;
        else m_cred[v]++;
      end else if (fw && m_ovc == v && !ik[v]) begin
        m_cred[v]--;
      end
    end
    if (own < 0) begin
      for (int k = 0; k < NPORT; k++) begin
        int p;
        p = (m_ptr + k) % NPORT;
        if (req[p] && !lck[vch[p]] && oc[vch[p]] > 0) begin
          m_owner = p; m_ovc = int'(vch[p]); m_ptr = (p + 1) % NPORT;
          break;
        end
      end
    end else if (fw && tl[own]) begin
      m_owner = -1;
    end

    if (fw) begin
      pend[m_ovc]++;
      psent[own]++;
      if (psent[own] == plen[own]) begin plen[own] = 0; psent[own] = 0; end
    end
    for (int p = 0; p < NPORT; p++) begin
      if (ld_mask[p] && plen[p] == 0 && $urandom_range(99) < ld_prob) begin
        plen[p]  = $urandom_range(ld_maxlen, 1);
        psent[p] = 0;
        pvc[p]   = (ld_vcmode == 2) ? $urandom_range(1) : ld_vcmode;
      end
    end
  endtask

  task automatic drain();
    ld_mask = '0; lck_rand = 1'b0; lck = '0; force_iack = '0;
    ds_en = 1'b1; ds_prob = 100; vprob = 100;
    for (int i = 0; i < 200; i++) begin
      bit busy;
      busy = (m_owner >= 0) || (pend[0] > 0) || (pend[1] > 0);
      for (int p = 0; p < NPORT; p++) if (plen[p] > 0) busy = 1'b1;
      if (!busy) break;
      step();
    end
  endtask

  // Monitor: compare each cycle's outputs and every forwarded flit
  initial begin : monitor
    stat_t e;
    fwd_t  f;
    forever begin
      @(negedge clk);
      if (stat_q.size() > 0) begin
        e = stat_q.pop_front();
        chk("grant",  int'(GRANT),  int'(e.grant));
        chk("sel",    int'(SEL),    int'(e.sel));
        chk("ovch",   int'(OVCH),   int'(e.ovch));
        chk("fwd",    int'(FWD),    int'(e.fwd));
        chk("ovalid", int'(OVALID), int'(e.ovalid));
        chk("credit", int'(CREDIT), int'(e.credit));
        chk("err",    int'(ERR),    int'(e.err));
      end
      if (rst_n && OVALID === 1'b1) begin
        if (fwd_q.size() == 0) begin
          chk("flit_unexpected", 1, 0);
        end else begin
          f = fwd_q.pop_front();
          chk("flit_cycle", cyc, f.cyc);
          chk("flit_port",  int'(SEL),  f.port);
          chk("flit_vc",    int'(OVCH), f.vc);
        end
      end
    end
  end

  initial begin : driver
    int   glog[$];
    logic [4:0] prevg;

    rst_n = 1'b0;
    zero_inputs();
    clear_sources();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant",  int'(GRANT),  0);
    chk("rst_ovalid", int'(OVALID), 0);
    chk("rst_credit", int'(CREDIT), 6'b100_100);
    chk("rst_err",    int'(ERR),    0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all five ports hold single-flit VC0 packets
    repeat (2) step();
    for (int p = 0; p < NPORT; p++) begin plen[p] = 1; psent[p] = 0; pvc[p] = 0; end
    ld_mask = 5'b11111; ld_prob = 100; ld_maxlen = 1; ld_vcmode = 0;
    prevg = '0;
    for (int i = 0; i < 14; i++) begin
      step();
      #1;
      if (GRANT != 5'd0 && prevg == 5'd0) glog.push_back(int'(SEL));
      prevg = GRANT;
    end
    chk("rr_count", (glog.size() >= 6) ? 1 : 0, 1);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("rr_order", glog[i], i % NPORT);
    drain();

    // Three-flit VC0 packet on port 2, no credit return
    ds_en = 1'b0;
    plen[2] = 3; psent[2] = 0; pvc[2] = 0;
    step(); #1;
    chk("b_grant_idle", int'(GRANT), 0);
    step(); #1;
    chk("b_grant", int'(GRANT), 5'b00100);
    chk("b_sel",   int'(SEL),   2);
    chk("b_fwd1",  int'(FWD),   5'b00100);
    step(); #1;
    chk("b_fwd2",  int'(FWD),   5'b00100);
    step(); #1;
    chk("b_fwd3",  int'(FWD),   5'b00100);
    step(); #1;
    chk("b_idle",    int'(GRANT),       0);
    chk("b_credit0", int'(CREDIT[2:0]), 1);
    drain();

    // Six-flit VC1 packet with only four credits
    ds_en = 1'b0;
    plen[3] = 6; psent[3] = 0; pvc[3] = 1;
    repeat (8) step();
    #1;
    chk("d_grant_held", int'(GRANT),       5'b01000);
    chk("d_credit1",    int'(CREDIT[5:3]), 0);
    chk("d_stall",      int'(OVALID),      0);
    force_iack = 2'b10;
    step(); #1;
    chk("d_iack_cycle", int'(OVALID), 0);
    step(); #1;
    chk("d_one_more",   int'(OVALID), 1);
    force_iack = 2'b00;
    step(); #1;
    chk("d_coincident", int'(CREDIT[5:3]), 1);
    chk("d_last_flit",  int'(OVALID),      1);
    step(); #1;
    chk("d_released",   int'(GRANT),       0);
    chk("d_credit_end", int'(CREDIT[5:3]), 0);
    drain();

    // VC0 locked: port1 (VC1) wins, port0 waits for the lock to drop
    lck = 2'b01;
    plen[0] = 2; psent[0] = 0; pvc[0] = 0;
    plen[1] = 3; psent[1] = 0; pvc[1] = 1;
    step();
    step(); #1;
    chk("e_port1", int'(GRANT), 5'b00010);
    repeat (6) step();
    #1;
    chk("e_locked_wait", int'(GRANT), 0);
    lck = 2'b00;
    step();
    step(); #1;
    chk("e_port0", int'(GRANT), 5'b00001);
    drain();

    // Random traffic
    ld_mask = 5'b11111; ld_prob = 30; ld_maxlen = 6; ld_vcmode = 2;
    vprob = 80; ds_prob = 50; lck_rand = 1'b1;
    repeat (400) step();
    drain();

    // Asynchronous reset in the middle of a packet
    plen[4] = 5; psent[4] = 0; pvc[4] = 0;
    repeat (3) step();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("g_grant",  int'(GRANT),  0);
    chk("g_ovalid", int'(OVALID), 0);
    chk("g_credit", int'(CREDIT), 6'b100_100);
    zero_inputs();
    clear_sources();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Credit return while already full
    force_iack = 2'b01;
    step();
    force_iack = 2'b00;
    step(); #1;
    chk("h_err",     int'(ERR),         1);
    chk("h_credit0", int'(CREDIT[2:0]), DEPTH);
    repeat (3) step();
    #1;
    chk("h_err_sticky", int'(ERR), 1);

    @(negedge clk);
    #1;
    chk("stat_q_empty", stat_q.size(), 0);
    chk("flit_q_empty", fwd_q.size(),  0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
